// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep checker: expected-function opcodes and FSM states.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Control/status and gate-facing signals of the sweep checker.
// The master side drives start/abort/op_sel and the gate output; the slave is the checker.
interface gate_sweep_ctrl_if #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [1:0]       op_sel;
    logic [N_IN-1:0]  gate_in;
    logic             gate_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             fail_valid;
    logic [N_IN-1:0]  first_fail_vec;

    modport master (
        output start, abort, op_sel, gate_y,
        input  gate_in, busy, done, pass, err_count, fail_valid, first_fail_vec
    );

    modport slave (
        input  start, abort, op_sel, gate_y,
        output gate_in, busy, done, pass, err_count, fail_valid, first_fail_vec
    );
endinterface

// File: rtl/gate_sweep_ref.sv
// Reference model of the gate under test: expected output bit for an opcode and input vector.
module gate_sweep_ref
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  op_e             op,
    input  logic [N_IN-1:0] vec,
    output logic            exp_y
);
    always_comb begin
        exp_y = 1'b0;
        case (op)
            OP_AND:  exp_y = &vec;
            OP_OR:   exp_y = |vec;
            OP_XOR:  exp_y = ^vec;
            OP_NAND: exp_y = ~(&vec);
            default: exp_y = 1'b0;
        endcase
    end
endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input vector onto a combinational gate, lets it settle, and checks gate_y
// against the reference for the latched opcode, counting and locating mismatches.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_sweep_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(SETTLE + 1);
    localparam logic [WAIT_W-1:0] SETTLE_CNT = WAIT_W'(SETTLE);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [N_IN-1:0]   gate_in_q, gate_in_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              fv_q, fv_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              exp_y;

    gate_sweep_ref #(.N_IN(N_IN)) u_ref (
        .op    (op_q),
        .vec   (gate_in_q),
        .exp_y (exp_y)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        gate_in_d = gate_in_q;
        wait_d    = wait_q;
        err_d     = err_q;
        fv_d      = fv_q;
        ffv_d     = ffv_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;

        // Abort outranks everything; error state is kept so a debugger can inspect it.
        if (bus.abort) begin
            state_d   = ST_IDLE;
            gate_in_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_d   = ST_WAIT;
                        op_d      = op_e'(bus.op_sel);
                        gate_in_d = '0;
                        wait_d    = SETTLE_CNT;
                        err_d     = '0;
                        fv_d      = 1'b0;
                        ffv_d     = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_q <= WAIT_W'(1)) begin
                        wait_d  = '0;
                        state_d = ST_CHECK;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (bus.gate_y != exp_y) begin
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (!fv_q) begin
                            fv_d  = 1'b1;
                            ffv_d = gate_in_q;
                        end
                    end
                    // pass must reflect this final check, so it looks at err_d
                    if (gate_in_q == '1) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d   = ST_WAIT;
                        gate_in_d = gate_in_q + N_IN'(1);
                        wait_d    = SETTLE_CNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_AND;
            gate_in_q <= '0;
            wait_q    <= '0;
            err_q     <= '0;
            fv_q      <= 1'b0;
            ffv_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            gate_in_q <= gate_in_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            fv_q      <= fv_d;
            ffv_q     <= ffv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign bus.gate_in        = gate_in_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.fail_valid     = fv_q;
    assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: an 8-bit-counter instance and a 1-bit-counter
// instance share clock, reset and a modelled gate whose output can be forced high.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic clk;
    logic rst_n;
    logic gy_tie1;
    int   checks;
    int   errors;

    gate_sweep_ctrl_if #(.N_IN(2), .CNT_W(8)) bus_a ();
    gate_sweep_ctrl_if #(.N_IN(2), .CNT_W(1)) bus_b ();

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .CNT_W(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Gate under check: a 2-input AND, or stuck at 1
    always_comb bus_a.gate_y = gy_tie1 ? 1'b1 : &bus_a.gate_in;
    always_comb bus_b.gate_y = gy_tie1 ? 1'b1 : &bus_b.gate_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_a(input logic [1:0] op);
        bus_a.op_sel = op;
        bus_a.start  = 1'b1;
        @(negedge clk);
        bus_a.start  = 1'b0;
    endtask

    // Waits for done on instance A; cyc counts rising edges after the start edge.
    task automatic wait_done_a(input int from, output int cyc);
        cyc = from;
        while (!bus_a.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus_a.gate_in !== 2'b00) begin errors++; $display("FAIL reset_gate_in: got %b want 00", bus_a.gate_in); end
        checks++; if ({bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail_valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail_valid}); end
        checks++; if (bus_a.err_count !== 8'd0 || bus_a.first_fail_vec !== 2'b00) begin errors++; $display("FAIL reset_err: got %0d/%b want 0/00", bus_a.err_count, bus_a.first_fail_vec); end
        checks++; if (bus_b.err_count !== 1'b0 || bus_b.done !== 1'b0) begin errors++; $display("FAIL reset_b: got err %0d done %b want 0 0", bus_b.err_count, bus_b.done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_and_ok();
        int k;
        gy_tie1 = 1'b0;
        start_a(2'd0);
        for (k = 0; k < 8; k++) begin
            checks++; if (bus_a.gate_in !== 2'(k / 2) || bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
                errors++; $display("FAIL and_seq[%0d]: got gate_in %b busy %b done %b want %b 1 0", k, bus_a.gate_in, bus_a.busy, bus_a.done, 2'(k / 2));
            end
            @(negedge clk);
        end
        checks++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) begin errors++; $display("FAIL and_done_cycle8: got done %b busy %b want 1 0", bus_a.done, bus_a.busy); end
        checks++; if (bus_a.pass !== 1'b1 || bus_a.err_count !== 8'd0 || bus_a.fail_valid !== 1'b0) begin
            errors++; $display("FAIL and_result: got pass %b err %0d fv %b want 1 0 0", bus_a.pass, bus_a.err_count, bus_a.fail_valid);
        end
    endtask

    task automatic test_stuck_one();
        int cyc;
        gy_tie1 = 1'b1;
        start_a(2'd0);
        checks++; if (bus_a.done !== 1'b0 || bus_a.pass !== 1'b0) begin errors++; $display("FAIL restart_done_drop: got done %b pass %b want 0 0", bus_a.done, bus_a.pass); end
        wait_done_a(0, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 8", cyc); end
        checks++; if (bus_a.err_count !== 8'd3 || bus_a.first_fail_vec !== 2'b00) begin errors++; $display("FAIL stuck_err: got %0d/%b want 3/00", bus_a.err_count, bus_a.first_fail_vec); end
        checks++; if (bus_a.fail_valid !== 1'b1 || bus_a.pass !== 1'b0) begin errors++; $display("FAIL stuck_flags: got fv %b pass %b want 1 0", bus_a.fail_valid, bus_a.pass); end
    endtask

    task automatic test_or_on_and();
        int cyc;
        gy_tie1 = 1'b0;
        start_a(2'd1);
        wait_done_a(0, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL or_done_cycle: got %0d want 8", cyc); end
        checks++; if (bus_a.err_count !== 8'd2 || bus_a.first_fail_vec !== 2'b01) begin errors++; $display("FAIL or_err: got %0d/%b want 2/01", bus_a.err_count, bus_a.first_fail_vec); end
        checks++; if (bus_a.fail_valid !== 1'b1 || bus_a.pass !== 1'b0) begin errors++; $display("FAIL or_flags: got fv %b pass %b want 1 0", bus_a.fail_valid, bus_a.pass); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        gy_tie1 = 1'b0;
        start_a(2'd0);
        repeat (2) @(negedge clk);
        bus_a.op_sel = 2'd2;
        bus_a.start  = 1'b1;
        @(negedge clk);
        bus_a.start  = 1'b0;
        checks++; if (bus_a.gate_in !== 2'b01 || bus_a.busy !== 1'b1) begin errors++; $display("FAIL busy_start_gate_in: got %b busy %b want 01 1", bus_a.gate_in, bus_a.busy); end
        wait_done_a(3, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL busy_start_done_cycle: got %0d want 8", cyc); end
        checks++; if (bus_a.pass !== 1'b1 || bus_a.err_count !== 8'd0) begin errors++; $display("FAIL busy_start_op_kept: got pass %b err %0d want 1 0", bus_a.pass, bus_a.err_count); end
    endtask

    task automatic test_abort_and_reset();
        gy_tie1 = 1'b0;
        start_a(2'd2);
        repeat (4) @(negedge clk);
        checks++; if (bus_a.gate_in !== 2'b10) begin errors++; $display("FAIL abort_pre_gate_in: got %b want 10", bus_a.gate_in); end
        bus_a.abort = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        bus_a.start = 1'b0;
        checks++; if (bus_a.gate_in !== 2'b00 || bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++; $display("FAIL abort_state: got gate_in %b done %b busy %b want 00 0 0", bus_a.gate_in, bus_a.done, bus_a.busy);
        end
        checks++; if (bus_a.err_count !== 8'd1 || bus_a.first_fail_vec !== 2'b01) begin errors++; $display("FAIL abort_held: got %0d/%b want 1/01", bus_a.err_count, bus_a.first_fail_vec); end
        repeat (3) @(negedge clk);
        checks++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.gate_in !== 2'b00) begin errors++; $display("FAIL abort_idle_stays: got busy %b done %b gate_in %b want 0 0 00", bus_a.busy, bus_a.done, bus_a.gate_in); end

        gy_tie1 = 1'b1;
        start_a(2'd0);
        repeat (3) @(negedge clk);
        checks++; if (bus_a.gate_in !== 2'b01 || bus_a.err_count !== 8'd1) begin errors++; $display("FAIL prerst_state: got %b/%0d want 01/1", bus_a.gate_in, bus_a.err_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_a.gate_in !== 2'b00 || bus_a.err_count !== 8'd0 || bus_a.first_fail_vec !== 2'b00) begin
            errors++; $display("FAIL async_rst_data: got %b/%0d/%b want 00/0/00", bus_a.gate_in, bus_a.err_count, bus_a.first_fail_vec);
        end
        checks++; if ({bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail_valid} !== 4'b0000) begin errors++; $display("FAIL async_rst_flags: got %b want 0000", {bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin errors++; $display("FAIL rst_no_partial_done: got done %b busy %b want 0 0", bus_a.done, bus_a.busy); end
    endtask

    task automatic test_saturation();
        int cyc;
        gy_tie1 = 1'b1;
        bus_b.op_sel = 2'd0;
        bus_b.start  = 1'b1;
        @(negedge clk);
        bus_b.start  = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_b.err_count !== 1'b1) begin errors++; $display("FAIL sat_after_two: got %0d want 1", bus_b.err_count); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus_b.err_count !== 1'b1) begin errors++; $display("FAIL sat_after_three: got %0d want 1", bus_b.err_count); end
        cyc = 5;
        while (!bus_b.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL sat_done_cycle: got %0d want 8", cyc); end
        checks++; if (bus_b.err_count !== 1'b1 || bus_b.pass !== 1'b0 || bus_b.first_fail_vec !== 2'b00) begin
            errors++; $display("FAIL sat_final: got err %0d pass %b ffv %b want 1 0 00", bus_b.err_count, bus_b.pass, bus_b.first_fail_vec);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        gy_tie1      = 1'b0;
        bus_a.start  = 1'b0;
        bus_a.abort  = 1'b0;
        bus_a.op_sel = 2'd0;
        bus_b.start  = 1'b0;
        bus_b.abort  = 1'b0;
        bus_b.op_sel = 2'd0;
        test_reset();
        test_and_ok();
        test_stuck_one();
        test_or_on_and();
        test_start_while_busy();
        test_abort_and_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
